// File: rtl/mem_bridge.sv
// Byte-wide program/data memory for the stack-machine core: combinational reads,
// two-cycle marker/data store decoding, and a streaming load port that holds the core in reset.
module mem_bridge #(
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 256,
  parameter logic [7:0]  WR_MARKER = 8'hFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] load_addr,
  output logic              cpu_reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              wr_strobe,
  output logic [1:0]        dbg_state   // 0 = IDLE, 1 = LOAD, 2 = ARMED
);

  // Load handshake: a byte transfers on every cycle where load_valid and load_ready are both high;
  // load_ready is high for exactly the cycles spent in LOAD and load_valid needs no hold.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [7:0]        mem_q [DEPTH];

  logic              load_we;
  logic              cpu_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  always_comb begin
    load_we   = (state_q == ST_LOAD) && load_valid && !reset;
    // A load request arriving in ARMED abandons the pending store.
    cpu_we    = (state_q == ST_ARMED) && !load_en && !reset;
    mem_we    = load_we || cpu_we;
    mem_waddr = load_we ? load_addr_q : cpu_addr;
    mem_wdata = load_we ? load_data : cpu_wdata;
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    if (load_we) begin
      load_addr_d = load_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    if (reset) begin
      state_d     = ST_IDLE;
      load_addr_d = '0;
    end else if (load_en) begin
      state_d = ST_LOAD;
      if (state_q != ST_LOAD) begin
        load_addr_d = '0;
      end
    end else begin
      case (state_q)
        ST_LOAD:  state_d = ST_IDLE;
        ST_IDLE:  state_d = (cpu_wdata == WR_MARKER) ? ST_ARMED : ST_IDLE;
        ST_ARMED: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
    end
  end

  // Memory contents deliberately survive reset so a loaded program outlives a core restart.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    load_ready = (state_q == ST_LOAD);
    load_addr  = load_addr_q;
    cpu_reset  = reset || (state_q == ST_LOAD);
    cpu_rdata  = (state_q == ST_LOAD) ? 8'h00 : mem_q[cpu_addr];
    wr_strobe  = cpu_we;
    dbg_state  = state_q;
  end

endmodule
